// File: rtl/rv_isa_pkg.sv
// Shared RV32I definitions: opcodes, format codes (same coding as the decoder's Imm_src),
// encoder FSM states and the canonical NOP.
package rv_isa_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_J = 3'b011,
    FMT_U = 3'b100,
    FMT_R = 3'b101
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // True when v is the sign-extension of its low 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic signed [31:0] s;
    s = $signed(v) >>> (bits - 1);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: fields + format code -> 32-bit word and range error.
module instr_pack
  import rv_isa_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_range_err
);

  always_comb begin
    o_word      = NOP;
    o_range_err = 1'b0;
    case (i_fmt)
      FMT_I: begin
        o_word      = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        o_range_err = !fits_signed(i_imm, 12);
      end
      FMT_S: begin
        o_word      = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        o_range_err = !fits_signed(i_imm, 12);
      end
      FMT_B: begin
        o_word      = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                       i_imm[4:1], i_imm[11], i_opcode};
        o_range_err = !fits_signed(i_imm, 13) || i_imm[0];
      end
      FMT_J: begin
        o_word      = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        o_range_err = !fits_signed(i_imm, 21) || i_imm[0];
      end
      FMT_U: begin
        o_word      = {i_imm[31:12], i_rd, i_opcode};
        o_range_err = (i_imm[11:0] != 12'd0);
      end
      FMT_R: begin
        o_word      = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
        o_range_err = 1'b0;
      end
      default: begin
        // Unknown format: emit a harmless NOP and flag it.
        o_word      = NOP;
        o_range_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I encoder and instruction-memory loader: accepts field bundles,
// packs them and writes them to consecutive word addresses via a write/ack handshake.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  enc_state_e        r_state;
  enc_state_e        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_last;
  logic              r_err;

  logic [31:0]       w_word;
  logic              w_range_err;
  logic              w_start;
  logic              w_accept;
  logic              w_ack;
  logic              w_wrap;

  instr_pack u_pack (
    .i_fmt       (in_fmt),
    .i_opcode    (in_opcode),
    .i_funct3    (in_funct3),
    .i_funct7    (in_funct7),
    .i_rd        (in_rd),
    .i_rs1       (in_rs1),
    .i_rs2       (in_rs2),
    .i_imm       (in_imm),
    .o_word      (w_word),
    .o_range_err (w_range_err)
  );

  assign w_start  = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
  assign w_accept = (r_state == ST_LOAD) && in_valid;
  assign w_ack    = (r_state == ST_WRITE) && mem_ack;
  // Ack at the top address without a last marker runs off the end of memory.
  assign w_wrap   = w_ack && !r_last && (&r_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) w_next = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        if (mem_ack) begin
          if (r_last || (&r_addr)) w_next = ST_DONE;
          else                     w_next = ST_LOAD;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) w_next = ST_LOAD;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= BASE_ADDR;
      r_wdata <= 32'd0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr <= BASE_ADDR;
        r_err  <= 1'b0;
      end
      if (w_accept) begin
        r_wdata <= w_word;
        r_last  <= in_last;
        if (w_range_err) r_err <= 1'b1;
      end
      if (w_ack) begin
        r_addr <= r_addr + 1'b1;
        if (w_wrap) r_err <= 1'b1;
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign err       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized sessions
// compared against an arithmetic encoding model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic        in_valid;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        in_last;
  logic        mem_ack, mem_ack2;

  logic        in_ready, mem_we, busy, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        in_ready2, mem_we2, busy2, done2, err2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .err(err)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_ack(mem_ack2),
    .busy(busy2), .done(done2), .err(err2)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference encoding from the ISA field layout, built with shifts and masks.
  function automatic logic [31:0] model_encode(
    input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [31:0] imm, output bit e);
    logic [31:0] u, base;
    int si;
    u  = imm;
    si = $signed(imm);
    base = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15);
    case (f)
      3'd0: begin
        model_encode = base | (32'(rd) << 7) | ((u & 32'hFFF) << 20);
        e = !(si >= -2048 && si <= 2047);
      end
      3'd1: begin
        model_encode = base | (32'(rs2) << 20) | (((u >> 5) & 32'h7F) << 25) | ((u & 32'h1F) << 7);
        e = !(si >= -2048 && si <= 2047);
      end
      3'd2: begin
        model_encode = base | (32'(rs2) << 20) | (((u >> 12) & 32'h1) << 31)
                     | (((u >> 5) & 32'h3F) << 25) | (((u >> 1) & 32'hF) << 8)
                     | (((u >> 11) & 32'h1) << 7);
        e = !(si >= -4096 && si <= 4095) || ((u & 32'h1) != 0);
      end
      3'd3: begin
        model_encode = 32'(op) | (32'(rd) << 7) | (((u >> 20) & 32'h1) << 31)
                     | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 32'h1) << 20)
                     | (((u >> 12) & 32'hFF) << 12);
        e = !(si >= -1048576 && si <= 1048575) || ((u & 32'h1) != 0);
      end
      3'd4: begin
        model_encode = 32'(op) | (32'(rd) << 7) | (u & 32'hFFFFF000);
        e = (u & 32'hFFF) != 0;
      end
      3'd5: begin
        model_encode = base | (32'(rd) << 7) | (32'(rs2) << 20) | (32'(f7) << 25);
        e = 1'b0;
      end
      default: begin
        model_encode = 32'h0000_0013;
        e = 1'b1;
      end
    endcase
  endfunction

  task automatic do_start(input bit sel);
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; start2 = 1'b0;
  endtask

  task automatic do_ack(input bit sel);
    if (sel) mem_ack2 = 1'b1; else mem_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0; mem_ack2 = 1'b0;
  endtask

  // Offers one bundle; returns at the negedge after acceptance (or after the budget).
  task automatic push(input bit sel, input logic [2:0] f, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic last, input int budget, output bit ok, output int acc_cyc);
    in_fmt = f; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    ok = 1'b0;
    acc_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      if ((sel ? in_ready2 : in_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk); @(negedge clk);
      acc_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 0; start2 = 0; in_valid = 0; in_fmt = 0; in_opcode = 0; in_funct3 = 0;
    in_funct7 = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0; in_last = 0;
    mem_ack = 0; mem_ack2 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, mem_we, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {in_ready, mem_we, busy, done, err});
    end
    checks++;
    if (mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs: addr=%h wdata=%h expected 0/0", mem_addr, mem_wdata);
    end
    checks++;
    if ({in_ready2, mem_we2, busy2, done2, err2} !== 5'b0 || mem_addr2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_dut2: flags=%b addr=%h expected 0", {in_ready2, mem_we2, busy2, done2, err2}, mem_addr2);
    end
  endtask

  task automatic test_addi;
    bit ok; int c;
    do_start(0);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL addi_start: in_ready=%b busy=%b expected 1/1", in_ready, busy);
    end
    mem_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (mem_addr !== 8'd0 || in_ready !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL ack_outside_write: addr=%h in_ready=%b we=%b expected 0/1/0", mem_addr, in_ready, mem_we);
    end
    push(0, 3'd0, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 10, ok, c);
    checks++;
    if (!ok || mem_we !== 1'b1 || mem_wdata !== 32'h00500093 || mem_addr !== 8'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL addi_write: ok=%0d we=%b wdata=%h addr=%h err=%b expected 1/1/00500093/0/0",
               ok, mem_we, mem_wdata, mem_addr, err);
    end
    do_ack(0);
    checks++;
    if (mem_we !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || mem_addr !== 8'd1) begin
      errors++;
      $display("FAIL addi_done: we=%b done=%b busy=%b addr=%h expected 0/1/0/1", mem_we, done, busy, mem_addr);
    end
  endtask

  task automatic test_back_to_back;
    bit ok1, ok2; int c1, c2;
    do_start(0);
    mem_ack = 1'b1;
    push(0, 3'd1, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd0, 5'd2, 32'd8, 1'b0, 10, ok1, c1);
    checks++;
    if (!ok1 || mem_we !== 1'b1 || mem_wdata !== 32'h00202423 || mem_addr !== 8'd0) begin
      errors++;
      $display("FAIL sw_write: ok=%0d we=%b wdata=%h addr=%h expected 1/1/00202423/0", ok1, mem_we, mem_wdata, mem_addr);
    end
    push(0, 3'd2, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1, 10, ok2, c2);
    checks++;
    if (!ok2 || mem_we !== 1'b1 || mem_wdata !== 32'hFE000EE3 || mem_addr !== 8'd1) begin
      errors++;
      $display("FAIL beq_write: ok=%0d we=%b wdata=%h addr=%h expected 1/1/FE000EE3/1", ok2, mem_we, mem_wdata, mem_addr);
    end
    checks++;
    if (c2 - c1 !== 2) begin
      errors++;
      $display("FAIL throughput: got %0d cycles between words expected 2", c2 - c1);
    end
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'd2 || err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: done=%b we=%b addr=%h err=%b expected 1/0/2/0", done, mem_we, mem_addr, err);
    end
  endtask

  task automatic test_delayed_ack;
    bit ok; int c;
    logic [31:0] words [2];
    words[0] = 32'h008000EF;
    words[1] = 32'h123452B7;
    do_start(0);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) push(0, 3'd3, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0, 10, ok, c);
      else        push(0, 3'd4, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 10, ok, c);
      repeat (3) @(negedge clk);
      checks++;
      if (!ok || mem_we !== 1'b1 || mem_wdata !== words[k] || mem_addr !== 8'(k) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL delayed_hold%0d: ok=%0d we=%b wdata=%h addr=%h rdy=%b expected 1/1/%h/%0d/0",
                 k, ok, mem_we, mem_wdata, mem_addr, in_ready, words[k], k);
      end
      do_ack(0);
      checks++;
      if (done !== (k == 1) || in_ready !== (k == 0) || mem_addr !== 8'(k + 1) || err !== 1'b0) begin
        errors++;
        $display("FAIL delayed_after%0d: done=%b rdy=%b addr=%h err=%b expected %0d/%0d/%0d/0",
                 k, done, in_ready, mem_addr, err, k == 1, k == 0, k + 1);
      end
    end
  endtask

  task automatic test_errors;
    bit ok; int c;
    logic [2:0]  fm  [3];
    logic [6:0]  op  [3];
    logic [31:0] im  [3];
    logic [31:0] exw [3];
    fm[0] = 3'd2; op[0] = 7'b1100011; im[0] = 32'd3;    exw[0] = 32'h00000163;
    fm[1] = 3'd0; op[1] = 7'b0010011; im[1] = 32'd4096; exw[1] = 32'h00000093;
    fm[2] = 3'd7; op[2] = 7'b0110011; im[2] = 32'd0;    exw[2] = 32'h00000013;
    for (int k = 0; k < 3; k++) begin
      do_start(0);
      checks++;
      if (err !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL err_cleared%0d: err=%b done=%b expected 0/0", k, err, done);
      end
      push(0, fm[k], op[k], 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, im[k], 1'b1, 10, ok, c);
      checks++;
      if (!ok || err !== 1'b1 || mem_wdata !== exw[k] || mem_we !== 1'b1) begin
        errors++;
        $display("FAIL err_case%0d: ok=%0d err=%b wdata=%h we=%b expected 1/1/%h/1",
                 k, ok, err, mem_wdata, mem_we, exw[k]);
      end
      do_ack(0);
      checks++;
      if (err !== 1'b1 || done !== 1'b1) begin
        errors++;
        $display("FAIL err_sticky%0d: err=%b done=%b expected 1/1", k, err, done);
      end
    end
  endtask

  task automatic test_wrap;
    bit ok; int c;
    do_start(1);
    for (int k = 0; k < 4; k++) begin
      push(1, 3'd0, 7'b0010011, 3'd0, 7'd0, 5'(k + 1), 5'd0, 5'd0, 32'(k), 1'b0, 10, ok, c);
      checks++;
      if (!ok || mem_we2 !== 1'b1 || mem_addr2 !== 2'(k) || mem_wdata2 !== model_encode_chk(k)) begin
        errors++;
        $display("FAIL wrap_write%0d: ok=%0d we=%b addr=%h wdata=%h expected 1/1/%0d/%h",
                 k, ok, mem_we2, mem_addr2, mem_wdata2, k, model_encode_chk(k));
      end
      do_ack(1);
    end
    checks++;
    if (err2 !== 1'b1 || done2 !== 1'b1 || mem_addr2 !== 2'd0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: err=%b done=%b addr=%h busy=%b expected 1/1/0/0", err2, done2, mem_addr2, busy2);
    end
    push(1, 3'd0, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd4, 1'b1, 4, ok, c);
    checks++;
    if (ok !== 1'b0) begin
      errors++;
      $display("FAIL wrap_fifth: accepted=%0d expected 0", ok);
    end
  endtask

  function automatic logic [31:0] model_encode_chk(input int k);
    bit e;
    return model_encode(3'd0, 7'b0010011, 3'd0, 7'd0, 5'(k + 1), 5'd0, 5'd0, 32'(k), e);
  endfunction

  task automatic test_reset_mid_write;
    bit ok; int c;
    do_start(0);
    push(0, 3'd0, 7'b0010011, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd7, 1'b0, 10, ok, c);
    do_ack(0);
    push(0, 3'd0, 7'b0010011, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'd9, 1'b0, 10, ok, c);
    checks++;
    if (!ok || mem_we !== 1'b1 || mem_addr !== 8'd1) begin
      errors++;
      $display("FAIL pre_reset: ok=%0d we=%b addr=%h expected 1/1/1", ok, mem_we, mem_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: we=%b rdy=%b busy=%b addr=%h wdata=%h expected 0/0/0/0/0",
               mem_we, in_ready, busy, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    do_start(0);
    checks++;
    if (in_ready !== 1'b1 || mem_addr !== 8'd0) begin
      errors++;
      $display("FAIL restart: rdy=%b addr=%h expected 1/0", in_ready, mem_addr);
    end
    push(0, 3'd5, 7'b0110011, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 10, ok, c);
    checks++;
    if (!ok || mem_wdata !== 32'h403100B3 || mem_addr !== 8'd0) begin
      errors++;
      $display("FAIL restart_write: ok=%0d wdata=%h addr=%h expected 1/403100B3/0", ok, mem_wdata, mem_addr);
    end
    do_ack(0);
  endtask

  task automatic test_random;
    bit ok, e; int c, n, d, mode;
    logic [2:0] f; logic [6:0] op, f7; logic [2:0] f3; logic [4:0] rd, rs1, rs2;
    logic [31:0] imm, exp_w;
    logic exp_err;
    for (int s = 0; s < 8; s++) begin
      do_start(0);
      n = $urandom_range(1, 6);
      exp_err = 1'b0;
      for (int k = 0; k < n; k++) begin
        f = 3'($urandom_range(0, 7));
        op = 7'($urandom); f3 = 3'($urandom); f7 = 7'($urandom);
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        mode = $urandom_range(0, 3);
        case (mode)
          0: imm = $urandom;
          1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
          2: imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
          default: imm = $urandom & 32'hFFFFF000;
        endcase
        exp_w = model_encode(f, op, f3, f7, rd, rs1, rs2, imm, e);
        exp_err = exp_err | e;
        push(0, f, op, f3, f7, rd, rs1, rs2, imm, (k == n - 1), 10, ok, c);
        d = $urandom_range(0, 3);
        repeat (d) @(negedge clk);
        checks++;
        if (!ok || mem_we !== 1'b1 || mem_wdata !== exp_w || mem_addr !== 8'(k) || err !== exp_err) begin
          errors++;
          $display("FAIL rand_s%0d_w%0d: ok=%0d we=%b wdata=%h addr=%h err=%b expected 1/1/%h/%0d/%b (fmt=%0d imm=%h)",
                   s, k, ok, mem_we, mem_wdata, mem_addr, err, exp_w, k, exp_err, f, imm);
        end
        do_ack(0);
        checks++;
        if (done !== (k == n - 1) || in_ready !== (k != n - 1) || mem_addr !== 8'(k + 1)) begin
          errors++;
          $display("FAIL rand_after_s%0d_w%0d: done=%b rdy=%b addr=%h expected %0d/%0d/%0d",
                   s, k, done, in_ready, mem_addr, k == n - 1, k != n - 1, k + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_delayed_ack();
    test_errors();
    test_wrap();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
